// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing: receiver state encoding plus the derivation of every
// line-timing constant (RX and TX) from the system clock frequency.
package ws2812_pkg;

    typedef enum logic [1:0] {
        RX_SYNC,
        RX_IDLE,
        RX_HIGH,
        RX_LOW
    } rx_state_e;

    localparam int BIT_RATE_HZ = 800000;
    localparam int PIXEL_BITS  = 24;

    function automatic int calc_cycle_count(input int sys_clk);
        return sys_clk / BIT_RATE_HZ;
    endfunction

    // A high pulse at or above 3/8 of a bit period decodes as 1.
    function automatic int calc_bit_thresh(input int cycle_count);
        return (cycle_count * 3) / 8;
    endfunction

    function automatic int calc_reset_detect(input int cycle_count);
        return 50 * cycle_count;
    endfunction

    // Transmitter high times: 0.4 us for a 0, 0.8 us for a 1.
    function automatic int calc_tx_h0(input int sys_clk);
        return sys_clk / 2500000;
    endfunction

    function automatic int calc_tx_h1(input int sys_clk);
        return sys_clk / 1250000;
    endfunction

    function automatic int calc_tx_reset(input int sys_clk);
        return calc_reset_detect(calc_cycle_count(sys_clk));
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the asynchronous DI line. With WS2812_RX_DEGLITCH_EN
// defined, the output only follows three consecutive equal synchronized samples.
module ws2812_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic di_i,
    output logic din_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= di_i;
            sync_q <= meta_q;
        end
    end

`ifdef WS2812_RX_DEGLITCH_EN
    logic [1:0] hist_q;
    logic       din_q;
    logic       din_d;

    // Output is combinational on agreement so the filter costs exactly two cycles.
    always_comb begin
        din_d = din_q;
        if ((sync_q == hist_q[0]) && (sync_q == hist_q[1])) begin
            din_d = sync_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b00;
            din_q  <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_q};
            din_q  <= din_d;
        end
    end

    assign din_o = din_d;
`else
    assign din_o = sync_q;
`endif

endmodule

// File: rtl/ws2812_rx.sv
// WS2812/SK6812 single-wire decoder: recovers 24-bit GRB pixels with a per-frame
// LED index. Optional input deglitch filter: define WS2812_RX_DEGLITCH_EN.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int SYSTEM_CLOCK = 50000000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        DI,
    output logic                        pixel_valid,
    output logic [$clog2(NUM_LEDS)-1:0] address,
    output logic [7:0]                  red_out,
    output logic [7:0]                  green_out,
    output logic [7:0]                  blue_out,
    output logic                        frame_done,
    output logic                        error,
    output logic                        overrun
);

    localparam int CYCLE_COUNT  = calc_cycle_count(SYSTEM_CLOCK);
    localparam int BIT_THRESH   = calc_bit_thresh(CYCLE_COUNT);
    localparam int RESET_DETECT = calc_reset_detect(CYCLE_COUNT);

    localparam int ADDR_W = $clog2(NUM_LEDS);
    localparam int IDX_W  = $clog2(NUM_LEDS + 1);
    localparam int HCNT_W = $clog2(CYCLE_COUNT + 1);
    localparam int LCNT_W = $clog2(RESET_DETECT + 1);

    localparam logic [HCNT_W-1:0] HCNT_LAST   = HCNT_W'(CYCLE_COUNT - 1);
    localparam logic [HCNT_W-1:0] HCNT_THRESH = HCNT_W'(BIT_THRESH);
    localparam logic [LCNT_W-1:0] LCNT_MAX    = LCNT_W'(RESET_DETECT);
    localparam logic [IDX_W-1:0]  IDX_LIMIT   = IDX_W'(NUM_LEDS);
    localparam logic [4:0]        LAST_BIT    = 5'(PIXEL_BITS - 1);

    function automatic logic [LCNT_W-1:0] sat_inc_low(input logic [LCNT_W-1:0] v);
        return (v == LCNT_MAX) ? v : v + LCNT_W'(1);
    endfunction

    logic din;

    rx_state_e state_q, state_d;

    logic [HCNT_W-1:0]     high_cnt_q, high_cnt_d;
    logic [LCNT_W-1:0]     low_cnt_q, low_cnt_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]      pix_idx_q, pix_idx_d;
    logic [PIXEL_BITS-1:0] shift_q, shift_d;
    logic                  bit_val;

    logic              pixel_valid_q, pixel_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              error_q, error_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [7:0]        red_q, red_d;
    logic [7:0]        green_q, green_d;
    logic [7:0]        blue_q, blue_d;

    ws2812_rx_sync u_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .di_i   (DI),
        .din_o  (din)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // In IDLE/LOW the line is known low, so din=1 there is always a rising edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_SYNC: begin
                if (!din && (low_cnt_q == LCNT_MAX)) state_d = RX_IDLE;
            end
            RX_IDLE: begin
                if (din) state_d = RX_HIGH;
            end
            RX_HIGH: begin
                if (!din) begin
                    state_d = RX_LOW;
                end else if (high_cnt_q == HCNT_LAST) begin
                    state_d = RX_SYNC;
                end
            end
            RX_LOW: begin
                if (din) begin
                    state_d = RX_HIGH;
                end else if (low_cnt_q == LCNT_MAX) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_SYNC;
        endcase
    end

    always_comb begin
        low_cnt_d     = din ? '0 : sat_inc_low(low_cnt_q);
        high_cnt_d    = high_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        pix_idx_d     = pix_idx_q;
        shift_d       = shift_q;
        address_d     = address_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        overrun_d     = overrun_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        error_d       = 1'b0;
        bit_val       = (high_cnt_q >= HCNT_THRESH);

        unique case (state_q)
            RX_SYNC: begin
                bit_cnt_d = '0;
                pix_idx_d = '0;
            end
            RX_IDLE: begin
                if (din) begin
                    high_cnt_d = HCNT_W'(1);
                    overrun_d  = 1'b0;
                end
            end
            RX_LOW: begin
                if (din) begin
                    high_cnt_d = HCNT_W'(1);
                end else if (low_cnt_q == LCNT_MAX) begin
                    frame_done_d = 1'b1;
                    error_d      = (bit_cnt_q != 5'd0);
                    bit_cnt_d    = '0;
                    pix_idx_d    = '0;
                end
            end
            RX_HIGH: begin
                if (din) begin
                    if (high_cnt_q == HCNT_LAST) begin
                        error_d   = 1'b1;
                        bit_cnt_d = '0;
                        pix_idx_d = '0;
                    end else begin
                        high_cnt_d = high_cnt_q + HCNT_W'(1);
                    end
                end else begin
                    shift_d = {shift_q[PIXEL_BITS-2:0], bit_val};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        // Pixels beyond the frame length are dropped but flagged.
                        if (pix_idx_q < IDX_LIMIT) begin
                            pixel_valid_d = 1'b1;
                            address_d     = pix_idx_q[ADDR_W-1:0];
                            green_d       = shift_d[23:16];
                            red_d         = shift_d[15:8];
                            blue_d        = shift_d[7:0];
                            pix_idx_d     = pix_idx_q + IDX_W'(1);
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            pix_idx_q     <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
            overrun_q     <= 1'b0;
            address_q     <= '0;
            red_q         <= 8'h00;
            green_q       <= 8'h00;
            blue_q        <= 8'h00;
        end else begin
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_idx_q     <= pix_idx_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            error_q       <= error_d;
            overrun_q     <= overrun_d;
            address_q     <= address_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    // Stale shift contents are harmless: bit_cnt restarts before any pixel is formed.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign error       = error_q;
    assign overrun     = overrun_q;
    assign address     = address_q;
    assign red_out     = red_q;
    assign green_out   = green_q;
    assign blue_out    = blue_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives WS2812 waveforms, records DUT strobes at the
// negative edge, and compares them against expected pixels queued by each test.
module tb_ws2812_rx;

    localparam int NUM_LEDS = 8;
    localparam int SYS_CLK  = 50000000;
    localparam int CC       = 62;
    localparam int RD       = 3100;
    localparam int T0       = 20;
    localparam int T1       = 40;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  g;
        logic [7:0]  r;
        logic [7:0]  b;
        logic [31:0] cyc;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       DI;
    logic       pixel_valid;
    logic [2:0] address;
    logic [7:0] red_out;
    logic [7:0] green_out;
    logic [7:0] blue_out;
    logic       frame_done;
    logic       error;
    logic       overrun;

    pix_t exp_q[$];
    pix_t obs_q[$];
    int   fd_q[$];
    int   err_q[$];

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int last_fall = 0;

    always #5 clk = ~clk;

    ws2812_rx #(
        .NUM_LEDS     (NUM_LEDS),
        .SYSTEM_CLOCK (SYS_CLK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .DI          (DI),
        .pixel_valid (pixel_valid),
        .address     (address),
        .red_out     (red_out),
        .green_out   (green_out),
        .blue_out    (blue_out),
        .frame_done  (frame_done),
        .error       (error),
        .overrun     (overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (pixel_valid === 1'b1)
                obs_q.push_back({5'd0, address, green_out, red_out, blue_out, 32'(cyc)});
            if (frame_done === 1'b1) fd_q.push_back(cyc);
            if (error === 1'b1) err_q.push_back(cyc);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        fd_q.delete();
        err_q.delete();
    endtask

    task automatic send_bit(input logic b, input int hi);
        DI = 1'b1;
        repeat (hi) @(negedge clk);
        DI = 1'b0;
        last_fall = cyc;
        repeat (CC - hi) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n, input int h0, input int h1);
        for (int i = 0; i < n; i++) send_bit(w[23-i], w[23-i] ? h1 : h0);
    endtask

    task automatic send_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        send_bits({g, r, b}, 24, T0, T1);
    endtask

    task automatic line_reset();
        DI = 1'b0;
        repeat (RD + 10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        DI = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pixel_valid, frame_done, error, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, want 0000", {pixel_valid, frame_done, error, overrun});
        end
        checks++;
        if (address !== 3'd0) begin
            errors++;
            $display("FAIL reset_address: got %0d, want 0", address);
        end
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h0) begin
            errors++;
            $display("FAIL reset_colour: got %h, want 000000", {red_out, green_out, blue_out});
        end
        reset_n = 1'b1;
        clear_q();
        line_reset();
        checks++;
        if (obs_q.size() + fd_q.size() + err_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle_events: got %0d events, want 0", obs_q.size() + fd_q.size() + err_q.size());
        end
    endtask

    task automatic test_loopback();
        pix_t e, o;
        int fall_end;
        clear_q();
        for (int k = 0; k < NUM_LEDS; k++) begin
            send_pixel(8'h3C, 8'(8'hA5 + k), 8'h0F);
            exp_q.push_back({8'(k), 8'h3C, 8'(8'hA5 + k), 8'h0F, 32'(last_fall + 3)});
        end
        fall_end = last_fall;
        line_reset();
        checks++;
        if (obs_q.size() != NUM_LEDS) begin
            errors++;
            $display("FAIL loopback_count: got %0d strobes, want %0d", obs_q.size(), NUM_LEDS);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL loopback_pixel: got none, want addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL loopback_pixel: got addr=%0d G=%h R=%h B=%h cyc=%0d, want addr=%0d G=%h R=%h B=%h cyc=%0d",
                             o.addr, o.g, o.r, o.b, o.cyc, e.addr, e.g, e.r, e.b, e.cyc);
                end
            end
        end
        checks++;
        if (fd_q.size() != 1 || fd_q[0] != fall_end + RD + 3) begin
            errors++;
            $display("FAIL loopback_frame_done: got %0d strobes first at %0d, want 1 at %0d",
                     fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, fall_end + RD + 3);
        end
        checks++;
        if (err_q.size() != 0) begin
            errors++;
            $display("FAIL loopback_error: got %0d strobes, want 0", err_q.size());
        end
    endtask

    task automatic test_bit_thresh();
        pix_t e, o;
        clear_q();
        send_bits(24'hC35A96, 24, 22, 23);
        exp_q.push_back({8'd0, 8'hC3, 8'h5A, 8'h96, 32'(last_fall + 3)});
        send_bits(24'h817E01, 24, 1, 61);
        exp_q.push_back({8'd1, 8'h81, 8'h7E, 8'h01, 32'(last_fall + 3)});
        line_reset();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL thresh_pixel: got none, want addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL thresh_pixel: got addr=%0d G=%h R=%h B=%h cyc=%0d, want addr=%0d G=%h R=%h B=%h cyc=%0d",
                             o.addr, o.g, o.r, o.b, o.cyc, e.addr, e.g, e.r, e.b, e.cyc);
                end
            end
        end
        checks++;
        if (fd_q.size() != 1 || err_q.size() != 0) begin
            errors++;
            $display("FAIL thresh_frame: got frame_done=%0d error=%0d, want 1 and 0", fd_q.size(), err_q.size());
        end
    endtask

    task automatic test_stuck_high();
        pix_t e;
        int rise;
        clear_q();
        send_bits(24'hFFFFFF, 5, T0, T1);
        DI = 1'b1;
        rise = cyc;
        repeat (CC) @(negedge clk);
        DI = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (err_q.size() != 1 || err_q[0] != rise + 64) begin
            errors++;
            $display("FAIL stuck_error: got %0d strobes first at %0d, want 1 at %0d",
                     err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, rise + 64);
        end
        repeat (1000) @(negedge clk);
        send_pixel(8'h55, 8'h66, 8'h77);
        line_reset();
        checks++;
        if (obs_q.size() != 0 || fd_q.size() != 0) begin
            errors++;
            $display("FAIL stuck_ignored: got pixels=%0d frame_done=%0d, want 0 and 0", obs_q.size(), fd_q.size());
        end
        send_pixel(8'h11, 8'h22, 8'h33);
        e = {8'd0, 8'h11, 8'h22, 8'h33, 32'(last_fall + 3)};
        line_reset();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== e) begin
            errors++;
            $display("FAIL stuck_recover: got %0d pixels first=%h, want 1 pixel %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, e);
        end
        checks++;
        if (fd_q.size() != 1 || err_q.size() != 1) begin
            errors++;
            $display("FAIL stuck_after: got frame_done=%0d error=%0d, want 1 and 1", fd_q.size(), err_q.size());
        end
    endtask

    task automatic test_truncated();
        pix_t e;
        int fall_end;
        clear_q();
        send_bits(24'hABCDEF, 10, T0, T1);
        fall_end = last_fall;
        line_reset();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL trunc_pixels: got %0d, want 0", obs_q.size());
        end
        checks++;
        if (err_q.size() != 1 || fd_q.size() != 1) begin
            errors++;
            $display("FAIL trunc_counts: got error=%0d frame_done=%0d, want 1 and 1", err_q.size(), fd_q.size());
        end else begin
            checks++;
            if (err_q[0] != fd_q[0] || fd_q[0] != fall_end + RD + 3) begin
                errors++;
                $display("FAIL trunc_timing: got error at %0d frame_done at %0d, want both at %0d",
                         err_q[0], fd_q[0], fall_end + RD + 3);
            end
        end
        send_pixel(8'hDE, 8'hAD, 8'hBE);
        e = {8'd0, 8'hDE, 8'hAD, 8'hBE, 32'(last_fall + 3)};
        line_reset();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== e) begin
            errors++;
            $display("FAIL trunc_next_frame: got %0d pixels first=%h, want 1 pixel %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, e);
        end
    endtask

    task automatic test_overrun();
        pix_t e, o;
        clear_q();
        for (int k = 0; k < NUM_LEDS + 1; k++) begin
            if (k == NUM_LEDS) begin
                checks++;
                if (overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL overrun_early: got %b, want 0", overrun);
                end
            end
            send_pixel(8'(k), 8'(8'h80 | k), 8'(8'hF0 - k));
            if (k < NUM_LEDS)
                exp_q.push_back({8'(k), 8'(k), 8'(8'h80 | k), 8'(8'hF0 - k), 32'(last_fall + 3)});
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b, want 1", overrun);
        end
        line_reset();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL overrun_pixel: got none, want addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL overrun_pixel: got addr=%0d G=%h R=%h B=%h cyc=%0d, want addr=%0d G=%h R=%h B=%h cyc=%0d",
                             o.addr, o.g, o.r, o.b, o.cyc, e.addr, e.g, e.r, e.b, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0 || fd_q.size() != 1 || err_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_frame: got extra=%0d frame_done=%0d error=%0d, want 0 1 0",
                     obs_q.size(), fd_q.size(), err_q.size());
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b, want 1", overrun);
        end
        clear_q();
        send_bits(24'h9C3A71, 1, T0, T1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b, want 0", overrun);
        end
        send_bits(24'h9C3A71 << 1, 23, T0, T1);
        e = {8'd0, 8'h9C, 8'h3A, 8'h71, 32'(last_fall + 3)};
        line_reset();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== e) begin
            errors++;
            $display("FAIL overrun_next_frame: got %0d pixels first=%h, want 1 pixel %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, e);
        end
    endtask

    task automatic test_reset_mid();
        pix_t e;
        clear_q();
        send_bits(24'h123456, 12, T0, T1);
        DI = 1'b1;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pixel_valid, frame_done, error, overrun} !== 4'b0000 || address !== 3'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: got strobes=%b address=%0d, want 0000 and 0",
                     {pixel_valid, frame_done, error, overrun}, address);
        end
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h0) begin
            errors++;
            $display("FAIL midreset_colour: got %h, want 000000", {red_out, green_out, blue_out});
        end
        @(negedge clk);
        DI = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        send_pixel(8'hA1, 8'hB2, 8'hC3);
        line_reset();
        checks++;
        if (obs_q.size() != 0 || fd_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_ignored: got pixels=%0d frame_done=%0d error=%0d, want 0 0 0",
                     obs_q.size(), fd_q.size(), err_q.size());
        end
        send_pixel(8'h5A, 8'hC3, 8'h3C);
        e = {8'd0, 8'h5A, 8'hC3, 8'h3C, 32'(last_fall + 3)};
        line_reset();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== e || fd_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_recover: got %0d pixels first=%h frame_done=%0d, want 1 pixel %h and 1",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, fd_q.size(), e);
        end
    endtask

    initial begin
        DI = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_bit_thresh();
        test_stuck_high();
        test_truncated();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

WS2812/SK6812 single-wire decoder: receives the 800 kHz pulse-width-coded stream that `ws2812` drives on `DO`, recovers each 24-bit GRB pixel, and presents it with a per-frame LED index. It is used for loopback self-test of the transmitter and to capture pixel streams from an upstream controller into the frame buffer.

## Interface
- `NUM_LEDS`, 8: pixels per frame; sets the `address` width as `$clog2(NUM_LEDS)`.
- `SYSTEM_CLOCK`, 50000000: `clk` frequency in Hz; all timing constants derive from it.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `DI` in 1: serial line, asynchronous to `clk`.
- `pixel_valid` out 1: one-cycle strobe; `address` and the colour outputs are valid while it is high.
- `address` out `$clog2(NUM_LEDS)`: index of the presented pixel, 0 for the first pixel after a line reset.
- `red_out`, `green_out`, `blue_out` out 8 each: decoded colour, MSB first on the wire, wire order G, R, B.
- `frame_done` out 1: one-cycle strobe when a line reset ends a frame that contained at least one bit.
- `error` out 1: one-cycle strobe on a pulse-width violation or a truncated pixel.
- `overrun` out 1: sticky; set when more than `NUM_LEDS` pixels arrive in one frame; cleared at the first bit of the next frame.

## Operation
- Constants: CYCLE_COUNT = SYSTEM_CLOCK/800000 (62 at 50 MHz). BIT_THRESH = CYCLE_COUNT*3/8 (23). RESET_DETECT = 50*CYCLE_COUNT (3100). All use integer division.
- `DI` passes through a 2-flop synchronizer, giving the internal signal `din`.
- `high_cnt` counts cycles with `din`=1 in the current pulse, starting at 1. `low_cnt` counts cycles with `din`=0 and saturates at RESET_DETECT.
- States:
  - SYNC: entered from reset and after any error. Waits for `low_cnt` == RESET_DETECT, then goes to IDLE. Rising edges in SYNC are ignored and reset `low_cnt`.
  - IDLE: the line is in reset. A rising edge on `din` goes to HIGH.
  - HIGH: counts `high_cnt`. On a falling edge the bit is (`high_cnt` >= BIT_THRESH) and it is shifted into a 24-bit register; the state goes to LOW. If `high_cnt` reaches CYCLE_COUNT, `error` strobes and the state goes to SYNC.
  - LOW: a rising edge goes to HIGH. `low_cnt` == RESET_DETECT ends the frame: `frame_done` strobes, and if the bit count is not 0 mod 24, `error` also strobes in the same cycle. The state goes to IDLE.
- On the 24th bit, the colour outputs load from the shift register as G=[23:16], R=[15:8], B=[7:0].
  - `pixel_valid` strobes and the bit count clears.
  - `address` = pixel index. The pixel index increments after each pixel and clears on frame end and in SYNC.
  - If the pixel index is >= `NUM_LEDS`, `pixel_valid` is suppressed and `overrun` is set.
- Gaps of any length below RESET_DETECT between bits or pixels are legal.
- Colour outputs hold their last value between strobes.

## Timing
- Reset values: `pixel_valid`, `frame_done`, `error`, `overrun` = 0; `address` = 0; colours = 0; state = SYNC.
- Decode latency: `pixel_valid` is asserted 3 cycles after the `DI` falling edge of bit 23 (2 cycles of synchronizer plus 1 register).
- `frame_done` is asserted RESET_DETECT+3 cycles after the last `DI` falling edge.
- `reset_n` asserted mid-pixel: all outputs return to reset values immediately and the partial pixel is discarded. After release, the block accepts no data until a full RESET_DETECT low period is seen.
- Simultaneous `error` and `frame_done` are allowed only for a truncated pixel.

## Configuration
- `WS2812_RX_DEGLITCH_EN` defined: `din` changes only after 3 consecutive equal synchronizer samples. This rejects glitches of 2 cycles or fewer and adds 2 cycles to every latency above; pulse widths are unchanged.
- Undefined: `din` is the synchronizer output directly.

## Structure
- `ws2812_pkg` holds the state enum and the CYCLE_COUNT, BIT_THRESH and RESET_DETECT derivation functions. The transmitter's H0/H1/RESET constants move there as well.
- Sub-module `ws2812_rx_sync` contains the synchronizer and the optional deglitch filter.

## Test plan
- `ws2812` TX loopback, NUM_LEDS=8, pixel k = (R=0xA5+k, G=0x3C, B=0x0F) -> 8 `pixel_valid` strobes with `address` 0..7 and matching colours, then 1 `frame_done`, `error` = 0.
- Hand-driven bits with high widths of 22 and 23 cycles, period 62 -> decoded as 0 and 1 respectively.
- `DI` held high for 62 cycles mid-pixel -> `error` strobes, and nothing is decoded until 3100 low cycles pass.
- 10 bits followed by 3100 low cycles -> `error` and `frame_done` in the same cycle, no `pixel_valid`, and the next frame starts at `address` 0.
- 9 pixels with NUM_LEDS=8 -> 8 strobes and `overrun` = 1; `overrun` clears on the first bit of the next frame.
- `reset_n` pulsed low during bit 12 -> outputs clear; the following pixel is ignored until the line-reset period completes.
